// File: rtl/mdr_mem_if_if.sv
// Bus-side and memory-side signal bundle of the MDR; master = MDR, slave = datapath/memory.
// Purely structural: no timing or backpressure of its own.
interface mdr_mem_if_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] busMuxOut;
    logic              mdr_in;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] q;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  busMuxOut, mdr_in, read, write, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_wdata, q, busy, done, err
    );

    modport slave (
        output busMuxOut, mdr_in, read, write, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_wdata, q, busy, done, err
    );
endinterface

// File: rtl/mdr_mem_if.sv
// Memory Data Register with req/ack memory FSM; command -> mem_req next cycle, ack -> done/q next cycle.
// Commands are ignored while busy; optional timeout abort under MDR_TIMEOUT_EN.
module mdr_mem_if #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clock,
    input  logic                clear,
    mdr_mem_if_if.master        m
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;

    logic [1:0]        state;
    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] wdata_r;
    logic              req_r;
    logic              we_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

`ifdef MDR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer;
    logic          expire;

    // This edge is the TIMEOUT_CYC-th one spent waiting without an ack.
    assign expire = (timer == TW'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            q_r     <= '0;
            wdata_r <= '0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            timer   <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (m.read) begin
                        state  <= RD;
                        req_r  <= 1'b1;
                        we_r   <= 1'b0;
                        busy_r <= 1'b1;
`ifdef MDR_TIMEOUT_EN
                        timer  <= '0;
`endif
                    end else if (m.write) begin
                        state   <= WR;
                        req_r   <= 1'b1;
                        we_r    <= 1'b1;
                        busy_r  <= 1'b1;
                        wdata_r <= q_r;
`ifdef MDR_TIMEOUT_EN
                        timer   <= '0;
`endif
                    end else if (m.mdr_in) begin
                        q_r <= m.busMuxOut;
                    end
                end
                RD: begin
                    // An ack on the expiry edge still completes normally.
                    if (m.mem_ack) begin
                        q_r    <= m.mem_rdata;
                        req_r  <= 1'b0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
`ifdef MDR_TIMEOUT_EN
                    else if (expire) begin
                        req_r  <= 1'b0;
                        we_r   <= 1'b0;
                        busy_r <= 1'b0;
                        err_r  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                WR: begin
                    if (m.mem_ack) begin
                        req_r  <= 1'b0;
                        we_r   <= 1'b0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
`ifdef MDR_TIMEOUT_EN
                    else if (expire) begin
                        req_r  <= 1'b0;
                        we_r   <= 1'b0;
                        busy_r <= 1'b0;
                        err_r  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                default: begin
                    state  <= IDLE;
                    req_r  <= 1'b0;
                    we_r   <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign m.q         = q_r;
    assign m.mem_wdata = wdata_r;
    assign m.mem_req   = req_r;
    assign m.mem_we    = we_r;
    assign m.busy      = busy_r;
    assign m.done      = done_r;
    assign m.err       = err_r;
endmodule
